// File: rtl/instruction_memory_if.sv
// Load/fetch bus of the IF-stage instruction memory: debug-unit byte loader,
// pc read address, and fill-level status.
interface instruction_memory_if #(
  parameter int WORD_SIZE      = 32,
  parameter int MEM_SIZE_WORDS = 64,
  parameter int PC_SIZE        = 32,
  parameter int BYTE_SIZE      = 8
);
  localparam int CNT_W = $clog2(MEM_SIZE_WORDS) + 1;

  logic                 i_clear;
  logic                 i_write;
  logic [BYTE_SIZE-1:0] i_byte;
  logic [PC_SIZE-1:0]   i_pc;
  logic [WORD_SIZE-1:0] o_instruction;
  logic                 o_full;
  logic                 o_empty;
  logic [CNT_W-1:0]     o_words;

  modport master (
    output i_clear, i_write, i_byte, i_pc,
    input  o_instruction, o_full, o_empty, o_words
  );

  modport slave (
    input  i_clear, i_write, i_byte, i_pc,
    output o_instruction, o_full, o_empty, o_words
  );
endinterface

// File: rtl/instruction_memory.sv
// Word-organised instruction memory: combinational fetch at pc, big-endian
// byte-assembly loader with fill-level status and no wrap-around.
module instruction_memory #(
  parameter int WORD_SIZE      = 32,
  parameter int MEM_SIZE_WORDS = 64,
  parameter int PC_SIZE        = 32,
  parameter int BYTE_SIZE      = 8
) (
  input logic i_clk,
  input logic i_reset,
  instruction_memory_if.slave bus
);
  localparam int AW    = $clog2(MEM_SIZE_WORDS);
  localparam int ASM_W = WORD_SIZE - BYTE_SIZE;

  localparam logic [1:0] PHASE0 = 2'd0;
  localparam logic [1:0] PHASE1 = 2'd1;
  localparam logic [1:0] PHASE2 = 2'd2;
  localparam logic [1:0] PHASE3 = 2'd3;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(MEM_SIZE_WORDS);

  logic [WORD_SIZE-1:0] mem [MEM_SIZE_WORDS];
  logic [ASM_W-1:0]     assembly;
  logic [1:0]           phase;
  logic [AW:0]          ptr;
  logic                 full;
  logic                 in_range;
  logic                 unused_pc_bits;

  assign full = (ptr == FULL_CNT);

  // Reset and clear share one path; reset simply wins by being OR'd in first.
  always_ff @(posedge i_clk) begin
    if (i_reset || bus.i_clear) begin
      for (int i = 0; i < MEM_SIZE_WORDS; i++) mem[i] <= '0;
      ptr      <= '0;
      phase    <= PHASE0;
      assembly <= '0;
    end else if (bus.i_write && !full) begin
      if (phase == PHASE3) begin
        mem[ptr[AW-1:0]] <= {assembly, bus.i_byte};
        ptr              <= ptr + 1'b1;
        assembly         <= '0;
        phase            <= PHASE0;
      end else begin
        assembly[ASM_W-1-BYTE_SIZE*int'(phase) -: BYTE_SIZE] <= bus.i_byte;
        case (phase)
          PHASE0:  phase <= PHASE1;
          PHASE1:  phase <= PHASE2;
          default: phase <= PHASE3;
        endcase
      end
    end
  end

  // Addresses beyond the array fetch a zero word (NOP) rather than aliasing.
  assign in_range       = (bus.i_pc[PC_SIZE-1:AW+2] == '0);
  assign unused_pc_bits = ^bus.i_pc[1:0];

  assign bus.o_instruction = in_range ? mem[bus.i_pc[AW+1:2]] : '0;
  assign bus.o_words       = ptr;
  assign bus.o_empty       = (ptr == '0);
  assign bus.o_full        = full;
endmodule

// File: tb/tb_instruction_memory.sv
// Directed bench for instruction_memory: stimulus queues expected values, a
// negedge monitor pops and compares them against the live outputs.
module tb_instruction_memory;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instruction_memory_if #(.WORD_SIZE(32), .MEM_SIZE_WORDS(64), .PC_SIZE(32), .BYTE_SIZE(8)) bus ();

  instruction_memory #(.WORD_SIZE(32), .MEM_SIZE_WORDS(64), .PC_SIZE(32), .BYTE_SIZE(8)) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  typedef struct {
    string       name;
    int          kind;   // 0 instruction, 1 words, 2 full, 3 empty
    logic [31:0] exp;
  } chk_t;

  chk_t q[$];
  int   checks = 0;
  int   errors = 0;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      chk_t        e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.kind)
        0:       act = bus.o_instruction;
        1:       act = 32'(bus.o_words);
        2:       act = 32'(bus.o_full);
        default: act = 32'(bus.o_empty);
      endcase
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 4) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL monitor_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic expect_val(string name, int kind, logic [31:0] exp);
    chk_t e;
    e.name = name;
    e.kind = kind;
    e.exp  = exp;
    q.push_back(e);
  endtask

  task automatic read_chk(string name, logic [31:0] pc, logic [31:0] exp);
    bus.i_pc = pc;
    expect_val(name, 0, exp);
    drain();
  endtask

  task automatic status_chk(string name, int words, logic full, logic empty);
    expect_val({name, "_words"}, 1, 32'(words));
    expect_val({name, "_full"},  2, 32'(full));
    expect_val({name, "_empty"}, 3, 32'(empty));
    drain();
  endtask

  task automatic wr(logic [7:0] b);
    bus.i_write = 1'b1;
    bus.i_byte  = b;
    @(posedge clk);
    #1;
    bus.i_write = 1'b0;
  endtask

  task automatic wr_word(logic [31:0] w);
    for (int i = 3; i >= 0; i--) wr(w[8*i +: 8]);
  endtask

  task automatic pulse_clear();
    bus.i_clear = 1'b1;
    @(posedge clk);
    #1;
    bus.i_clear = 1'b0;
  endtask

  initial begin
    bus.i_clear = 1'b0;
    bus.i_write = 1'b0;
    bus.i_byte  = 8'h00;
    bus.i_pc    = 32'h0;

    // 1: reset state
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    read_chk("rst_pc0",   32'd0,   32'h0);
    read_chk("rst_pc4",   32'd4,   32'h0);
    read_chk("rst_pc252", 32'd252, 32'h0);
    status_chk("rst", 0, 1'b0, 1'b1);

    // 2: two big-endian words
    wr_word(32'h2001000A);
    status_chk("w1", 1, 1'b0, 1'b0);
    wr_word(32'h8C020004);
    status_chk("w2", 2, 1'b0, 1'b0);
    read_chk("w2_pc0", 32'd0, 32'h2001000A);
    read_chk("w2_pc4", 32'd4, 32'h8C020004);
    read_chk("w2_pc6", 32'd6, 32'h8C020004);

    // 3: partial word invisible, clear, reload
    wr(8'hAA); wr(8'hBB); wr(8'hCC);
    status_chk("part", 2, 1'b0, 1'b0);
    read_chk("part_pc8", 32'd8, 32'h0);
    pulse_clear();
    status_chk("clr", 0, 1'b0, 1'b1);
    read_chk("clr_pc4", 32'd4, 32'h0);
    wr_word(32'h11223344);
    status_chk("reload", 1, 1'b0, 1'b0);
    read_chk("reload_pc0", 32'd0, 32'h11223344);

    // 4: fill completely, then writes while full are ignored
    pulse_clear();
    for (int i = 0; i < 256; i++) wr(8'(i));
    status_chk("fill", 64, 1'b1, 1'b0);
    read_chk("fill_pc252", 32'd252, 32'hFCFDFEFF);
    read_chk("fill_pc0",   32'd0,   32'h00010203);
    read_chk("fill_pc128", 32'd128, 32'h80818283);
    wr_word(32'hFFFFFFFF);
    status_chk("ovf", 64, 1'b1, 1'b0);
    read_chk("ovf_pc0",   32'd0,   32'h00010203);
    read_chk("ovf_pc252", 32'd252, 32'hFCFDFEFF);

    // 5: out-of-range addresses read NOP
    read_chk("oor_pc256",  32'd256,        32'h0);
    read_chk("oor_pcmax",  32'hFFFFFFFC,   32'h0);
    read_chk("oor_pc255",  32'd255,        32'hFCFDFEFF);

    // 6a: clear beats a simultaneous 4th-byte write
    pulse_clear();
    wr(8'hA1); wr(8'hA2); wr(8'hA3);
    bus.i_write = 1'b1;
    bus.i_clear = 1'b1;
    bus.i_byte  = 8'hA4;
    @(posedge clk);
    #1;
    bus.i_write = 1'b0;
    bus.i_clear = 1'b0;
    status_chk("wrclr", 0, 1'b0, 1'b1);
    read_chk("wrclr_pc0", 32'd0, 32'h0);
    wr_word(32'h01020304);
    read_chk("after_clr_pc0", 32'd0, 32'h01020304);

    // 6b: reset mid-word discards pending bytes
    wr(8'h77); wr(8'h66);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    status_chk("rstmid", 0, 1'b0, 1'b1);
    read_chk("rstmid_pc0", 32'd0, 32'h0);
    read_chk("rstmid_pc4", 32'd4, 32'h0);

    // 6c: same-cycle read of the word being completed returns the old value
    wr(8'hDE); wr(8'hAD); wr(8'hBE);
    bus.i_pc    = 32'd0;
    bus.i_write = 1'b1;
    bus.i_byte  = 8'hEF;
    expect_val("samecyc_pc0", 0, 32'h0);
    drain();
    @(posedge clk);
    #1;
    bus.i_write = 1'b0;
    read_chk("newword_pc0", 32'd0, 32'hDEADBEEF);
    status_chk("newword", 1, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
